// File: rtl/wreg_ring_db_pkg.sv
// Shared types and helpers for the double-buffered circular weight register.
// Holds the shadow-bank state encoding and the column-pointer width helper.
package wreg_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } shadow_state_e;

   // Pointer width, never narrower than one bit.
   function automatic int ptr_w(input int k_w);
      int w;
      w = $clog2(k_w);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/wreg_ring_db_if.sv
// Load channel from the weight SRAM read port into the shadow bank.
// One beat carries one kernel column, row i on lane i.
interface wreg_ring_db_if #(
   parameter int DATA_W = 8,
   parameter int K_H    = 3
);
   logic                         in_valid;
   logic                         in_ready;
   logic [K_H-1:0][DATA_W-1:0]   in_data;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/wreg_ring_db_bank.sv
// K_W columns of K_H x DATA_W weights: single-column write, whole-bank load,
// and a column read mux. Instantiated once as shadow and once as active.
module wreg_bank
   import wreg_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int K_H    = 3,
   parameter int K_W    = 3,
   parameter int PTR_W  = ptr_w(K_W)
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  clear,
   input  logic                                  col_we,
   input  logic [PTR_W-1:0]                      col_waddr,
   input  logic [K_H-1:0][DATA_W-1:0]            col_wdata,
   input  logic                                  load_en,
   input  logic [K_W-1:0][K_H-1:0][DATA_W-1:0]   load_data,
   input  logic [PTR_W-1:0]                      rd_col,
   output logic [K_H-1:0][DATA_W-1:0]            rd_data,
   output logic [K_W-1:0][K_H-1:0][DATA_W-1:0]   bank_data
);

   genvar gi;
   generate
      for (gi = 0; gi < K_W; gi++) begin : g_col
         logic [K_H-1:0][DATA_W-1:0] col_q;
         logic [K_H-1:0][DATA_W-1:0] col_d;

         // Clear wins over a full-bank load, which wins over a column write.
         always_comb begin
            col_d = col_q;
            if (clear) begin
               col_d = '0;
            end else if (load_en) begin
               col_d = load_data[gi];
            end else if (col_we && (col_waddr == PTR_W'(gi))) begin
               col_d = col_wdata;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               col_q <= '0;
            end else begin
               col_q <= col_d;
            end
         end

         assign bank_data[gi] = col_q;
      end
   endgenerate

   always_comb begin
      rd_data = '0;
      for (int c = 0; c < K_W; c++) begin
         if (rd_col == PTR_W'(c)) begin
            rd_data = bank_data[c];
         end
      end
   end

endmodule

// File: rtl/wreg_ring_db.sv
// Double-buffered circular weight register: the shadow bank loads the next kernel
// while the active bank rotates one column per shift. Optional col_zero: WREG_ZERO_FLAG_EN.
module wreg_ring_db
   import wreg_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int K_H    = 3,
   parameter int K_W    = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear,
   wreg_ring_db_if.slave                 ld,
   input  logic                          swap,
   input  logic                          shift,
   output logic [K_H-1:0][DATA_W-1:0]    out_data,
   output logic [$clog2(K_W)-1:0]        out_col,
   output logic                          wrap,
   output logic                          active_valid,
   output logic                          shadow_full
`ifdef WREG_ZERO_FLAG_EN
   ,
   output logic                          col_zero
`endif
);

   localparam int PTR_W = ptr_w(K_W);

   shadow_state_e                         state_q;
   logic [PTR_W-1:0]                      ld_cnt_q;
   logic [PTR_W-1:0]                      col_ptr_q;
   logic [PTR_W-1:0]                      col_ptr_d;
   logic                                  wrap_q;
   logic                                  wrap_d;
   logic                                  active_valid_q;
   logic                                  active_valid_d;

   logic                                  beat_acc;
   logic                                  ld_last;
   logic                                  swap_acc;
   logic                                  shift_acc;
   logic [K_W-1:0][K_H-1:0][DATA_W-1:0]   shadow_data;
   logic [K_W-1:0][K_H-1:0][DATA_W-1:0]   active_data;
   logic [K_H-1:0][DATA_W-1:0]            shadow_rd_unused;

   assign shadow_full  = (state_q == FULL);
   assign ld.in_ready  = (state_q != FULL);
   assign beat_acc     = ld.in_valid && ld.in_ready;
   assign ld_last      = (ld_cnt_q == PTR_W'(K_W - 1));
   // A swap must see the registered FULL flag; the cycle of the last beat is too early.
   assign swap_acc     = swap && shadow_full;
   assign shift_acc    = shift && active_valid_q && !swap_acc;

   wreg_bank #(
      .DATA_W (DATA_W),
      .K_H    (K_H),
      .K_W    (K_W),
      .PTR_W  (PTR_W)
   ) u_shadow (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .col_we    (beat_acc),
      .col_waddr (ld_cnt_q),
      .col_wdata (ld.in_data),
      .load_en   (1'b0),
      .load_data ('0),
      .rd_col    ('0),
      .rd_data   (shadow_rd_unused),
      .bank_data (shadow_data)
   );

   wreg_bank #(
      .DATA_W (DATA_W),
      .K_H    (K_H),
      .K_W    (K_W),
      .PTR_W  (PTR_W)
   ) u_active (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .col_we    (1'b0),
      .col_waddr ('0),
      .col_wdata ('0),
      .load_en   (swap_acc),
      .load_data (shadow_data),
      .rd_col    (col_ptr_q),
      .rd_data   (out_data),
      .bank_data (active_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         ld_cnt_q <= '0;
      end else if (clear) begin
         state_q  <= EMPTY;
         ld_cnt_q <= '0;
      end else begin
         case (state_q)
            EMPTY, FILLING: begin
               if (beat_acc) begin
                  state_q <= ld_last ? FULL : FILLING;
               end
            end
            FULL: begin
               if (swap_acc) begin
                  state_q <= EMPTY;
               end
            end
            default: state_q <= EMPTY;
         endcase
         if (beat_acc) begin
            ld_cnt_q <= ld_last ? '0 : ld_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      col_ptr_d      = col_ptr_q;
      wrap_d         = 1'b0;
      active_valid_d = active_valid_q;
      if (clear) begin
         col_ptr_d      = '0;
         active_valid_d = 1'b0;
      end else if (swap_acc) begin
         col_ptr_d      = '0;
         active_valid_d = 1'b1;
      end else if (shift_acc) begin
         if (col_ptr_q == PTR_W'(K_W - 1)) begin
            col_ptr_d = '0;
            wrap_d    = 1'b1;
         end else begin
            col_ptr_d = col_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_ptr_q      <= '0;
         wrap_q         <= 1'b0;
         active_valid_q <= 1'b0;
      end else begin
         col_ptr_q      <= col_ptr_d;
         wrap_q         <= wrap_d;
         active_valid_q <= active_valid_d;
      end
   end

   assign out_col      = col_ptr_q;
   assign wrap         = wrap_q;
   assign active_valid = active_valid_q;

`ifdef WREG_ZERO_FLAG_EN
   assign col_zero = active_valid_q && (out_data == '0);
`endif

endmodule

// File: tb/tb_wreg_ring_db.sv
// Directed bench for wreg_ring_db (DATA_W=8, K_H=3, K_W=3): load, rotate,
// concurrent load, illegal swaps, clear priority and asynchronous reset.
module tb_wreg_ring_db;

   logic          clk;
   logic          rst_n;
   logic          clear;
   logic          swap;
   logic          shift;
   logic [23:0]   out_data;
   logic [1:0]    out_col;
   logic          wrap;
   logic          active_valid;
   logic          shadow_full;
`ifdef WREG_ZERO_FLAG_EN
   logic          col_zero;
`endif

   int total = 0;
   int bad   = 0;

   wreg_ring_db_if #(.DATA_W(8), .K_H(3)) ld_if ();

   wreg_ring_db #(
      .DATA_W (8),
      .K_H    (3),
      .K_W    (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .ld           (ld_if),
      .swap         (swap),
      .shift        (shift),
      .out_data     (out_data),
      .out_col      (out_col),
      .wrap         (wrap),
      .active_valid (active_valid),
      .shadow_full  (shadow_full)
`ifdef WREG_ZERO_FLAG_EN
      ,
      .col_zero     (col_zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {lane2,lane1,lane0, out_col, wrap, active_valid, shadow_full, in_ready}
   logic [29:0] obs;
   assign obs = {out_data, out_col, wrap, active_valid, shadow_full, ld_if.in_ready};

   function automatic logic [23:0] col3(input int a, input int b, input int c);
      return {8'(c), 8'(b), 8'(a)};
   endfunction

   function automatic logic [29:0] exp_v(input int a, input int b, input int c, input int col,
                                         input bit wr, input bit av, input bit sf, input bit rdy);
      return {8'(c), 8'(b), 8'(a), 2'(col), wr, av, sf, rdy};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [29:0] e;
      e = exp_v(0, 0, 0, 0, 0, 0, 0, 1);
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL reset_hold obs=%h want=%h", obs, e);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL reset_release obs=%h want=%h", obs, e);
      end
   endtask

   task automatic test_load();
      logic [29:0] e;
      ld_if.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ld_if.in_data = col3(3*i+1, 3*i+2, 3*i+3);
         step();
         e = (i == 2) ? exp_v(0, 0, 0, 0, 0, 0, 1, 0) : exp_v(0, 0, 0, 0, 0, 0, 0, 1);
         $display("load beat %0d data=%h obs=%h", i, ld_if.in_data, obs);
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL load_beat%0d obs=%h want=%h", i, obs, e);
         end
      end
      ld_if.in_data = col3(99, 99, 99);
      step();
      e = exp_v(0, 0, 0, 0, 0, 0, 1, 0);
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL load_extra obs=%h want=%h", obs, e);
      end
      ld_if.in_valid = 1'b0;
   endtask

   task automatic test_rotate();
      logic [29:0] e;
      int tbl [4][5] = '{'{4, 5, 6, 1, 0}, '{7, 8, 9, 2, 0}, '{1, 2, 3, 0, 1}, '{4, 5, 6, 1, 0}};
      swap = 1'b1;
      step();
      swap = 1'b0;
      e = exp_v(1, 2, 3, 0, 0, 1, 0, 1);
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL rot_swap obs=%h want=%h", obs, e);
      end
      shift = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         e = exp_v(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4] != 0, 1, 0, 1);
         $display("shift %0d obs=%h", i, obs);
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL rot_shift%0d obs=%h want=%h", i, obs, e);
         end
      end
      shift = 1'b0;
   endtask

   task automatic test_concurrency();
      logic [29:0] e;
      int tbl [3][7] = '{'{7, 8, 9, 2, 0, 0, 1}, '{1, 2, 3, 0, 1, 0, 1}, '{4, 5, 6, 1, 0, 1, 0}};
      shift = 1'b1;
      ld_if.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ld_if.in_data = col3(10+3*i, 11+3*i, 12+3*i);
         step();
         e = exp_v(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4] != 0, 1,
                   tbl[i][5] != 0, tbl[i][6] != 0);
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL conc_beat%0d obs=%h want=%h", i, obs, e);
         end
      end
      ld_if.in_valid = 1'b0;
      step();
      e = exp_v(7, 8, 9, 2, 0, 1, 1, 0);
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL conc_pre_swap obs=%h want=%h", obs, e);
      end
      swap = 1'b1;
      step();
      swap = 1'b0;
      e = exp_v(10, 11, 12, 0, 0, 1, 0, 1);
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL conc_swap obs=%h want=%h", obs, e);
      end
      step();
      e = exp_v(13, 14, 15, 1, 0, 1, 0, 1);
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL conc_after obs=%h want=%h", obs, e);
      end
      shift = 1'b0;
   endtask

   task automatic test_illegal_swap();
      logic [29:0] e;
      ld_if.in_valid = 1'b1;
      ld_if.in_data  = col3(20, 21, 22);
      step();
      ld_if.in_data  = col3(23, 24, 25);
      step();
      ld_if.in_valid = 1'b0;
      swap = 1'b1;
      step();
      e = exp_v(13, 14, 15, 1, 0, 1, 0, 1);
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL ill_filling obs=%h want=%h", obs, e);
      end
      ld_if.in_valid = 1'b1;
      ld_if.in_data  = col3(26, 27, 28);
      step();
      ld_if.in_valid = 1'b0;
      e = exp_v(13, 14, 15, 1, 0, 1, 1, 0);
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL ill_last_beat obs=%h want=%h", obs, e);
      end
      step();
      swap = 1'b0;
      e = exp_v(20, 21, 22, 0, 0, 1, 0, 1);
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL ill_swap_ok obs=%h want=%h", obs, e);
      end
   endtask

   task automatic test_clear();
      logic [29:0] e;
      int tbl [3][4] = '{'{30, 31, 32, 0}, '{33, 34, 35, 1}, '{36, 37, 38, 2}};
      ld_if.in_valid = 1'b1;
      ld_if.in_data  = col3(40, 41, 42);
      step();
      clear = 1'b1;
      swap  = 1'b1;
      shift = 1'b1;
      ld_if.in_data = col3(43, 44, 45);
      step();
      clear = 1'b0;
      swap  = 1'b0;
      ld_if.in_valid = 1'b0;
      e = exp_v(0, 0, 0, 0, 0, 0, 0, 1);
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL clr_now obs=%h want=%h", obs, e);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL clr_shift%0d obs=%h want=%h", i, obs, e);
         end
      end
      shift = 1'b0;
      ld_if.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ld_if.in_data = col3(tbl[i][0], tbl[i][1], tbl[i][2]);
         step();
      end
      ld_if.in_valid = 1'b0;
      swap = 1'b1;
      step();
      swap = 1'b0;
      for (int i = 0; i < 3; i++) begin
         e = exp_v(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], 0, 1, 0, 1);
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL clr_reload%0d obs=%h want=%h", i, obs, e);
         end
         shift = (i < 2);
         if (i < 2) step();
      end
      shift = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [29:0] e;
      shift = 1'b1;
      step();
      e = exp_v(30, 31, 32, 0, 1, 1, 0, 1);
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL ar_wrap obs=%h want=%h", obs, e);
      end
      #2;
      rst_n = 1'b0;
      #1;
      e = exp_v(0, 0, 0, 0, 0, 0, 0, 1);
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL ar_immediate obs=%h want=%h", obs, e);
      end
      shift = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL ar_after obs=%h want=%h", obs, e);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clear = 1'b0;
      swap  = 1'b0;
      shift = 1'b0;
      ld_if.in_valid = 1'b0;
      ld_if.in_data  = '0;
      #12;
      test_reset();
      test_load();
      test_rotate();
      test_concurrency();
      test_illegal_swap();
      test_clear();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wreg_ring_db.md
Name: wreg_ring_db

Overview:
- Parametrised, double-buffered circular weight register that feeds one kernel column per cycle to a K_H-row PE column.
- Successor to the single-bank 8-bit circular weight register, generalised in data width and kernel size.
- Adds a shadow bank with a valid/ready load handshake, so the next kernel loads while the active kernel rotates.
- Adds a column pointer and a wrap pulse for the conv controller.
- Sits between the weight SRAM read port and the PE array weight inputs.

Parameters:
DATA_W, 8, weight element width in bits
K_H, 3, kernel rows = parallel output lanes
K_W, 3, kernel columns = ring depth (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
clear  in  1  sync clear of both banks and all state
in_valid  in  1  load beat valid
in_ready  out  1  shadow bank can accept a beat
in_data  in  K_H x DATA_W  one kernel column, row i on lane i
swap  in  1  request shadow->active transfer
shift  in  1  advance active ring by one column
out_data  out  K_H x DATA_W  active[i][col_ptr], all rows incl. row 0
out_col  out  $clog2(K_W)  current col_ptr
wrap  out  1  1-cycle pulse, col_ptr went K_W-1 -> 0
active_valid  out  1  active bank holds a complete kernel
shadow_full  out  1  shadow bank complete, swap allowed

Behaviour:
- Reset state (rst_n low, async): both banks 0, ld_cnt=0, col_ptr=0, shadow state EMPTY, active_valid=0, wrap=0. Hence out_data=0 and in_ready=1.
- clear: synchronous, same effect as reset. Highest priority over load, swap and shift in the same cycle. A clear or reset mid-load discards partial beats.
- Shadow FSM:
  - EMPTY -> FILLING on the first accepted beat.
  - FILLING -> FULL on the beat where ld_cnt==K_W-1.
  - FULL -> EMPTY on an accepted swap.
- in_ready = (state != FULL); the signal is combinational from state only.
- Beat accept: in_valid && in_ready. Writes shadow[i][ld_cnt] <= in_data[i] for all i, then ld_cnt <= (ld_cnt==K_W-1) ? 0 : ld_cnt+1.
- Swap is accepted only when shadow_full==1 (registered). Effect at the next edge:
  - active <= shadow; active_valid <= 1; col_ptr <= 0; state <= EMPTY.
  - Swap with shadow_full==0 is ignored, with no error flag.
  - Swap on the same cycle as the last load beat is ignored, because shadow_full is still 0.
- Shift is honoured only when active_valid==1 and no swap is accepted that cycle. Accepted swap beats shift; the dropped shift is not queued.
- On shift: col_ptr <= (col_ptr==K_W-1) ? 0 : col_ptr+1. wrap <= 1 for exactly the next cycle when col_ptr was K_W-1; otherwise wrap <= 0.
- Loading into shadow proceeds concurrently with shift on active; there is no interaction.
- Output timing:
  - out_data is combinational from registered active and col_ptr, giving 1-cycle latency from a shift or swap edge to the new column.
  - out_data shows a new kernel's column 0 in the cycle after an accepted swap.
- Active bank contents never change except on swap, clear or reset. The ring is non-destructive and rotates indefinitely.

Optional Feature:
- Macro: WREG_ZERO_FLAG_EN.
- Defined: adds output col_zero (1 bit), = 1 when all K_H lanes of out_data are zero and active_valid==1, for PE zero-skip gating. It is combinational and reset-low via active_valid.
- Undefined: the port is absent and no logic is added.

Decomposition:
- Package wreg_pkg holds the shadow state enum typedef (EMPTY, FILLING, FULL) and the function ptr_w(K_W) returning max(1,$clog2(K_W)).
- Storage is natural as one sub-module wreg_bank, instantiated twice (shadow, active). It is a K_H x K_W x DATA_W register array with a column write port, a full-bank parallel load and a column read mux.

Test Plan:
- Reset/load: reset, 3 beats of columns {1,2,3},{4,5,6},{7,8,9} (lanes 0..2).
  - shadow_full=1 and in_ready=0 after the 3rd beat.
  - A 4th in_valid is not accepted.
- Swap/rotate: swap, then shift x4.
  - out_data = {1,2,3}, {4,5,6}, {7,8,9}, {1,2,3}, {4,5,6}.
  - wrap high only in the cycle {1,2,3} reappears.
  - out_col 0,1,2,0,1.
- Concurrency: load a second kernel {10..18} while shifting, then swap mid-rotation with col_ptr=2.
  - Next cycle out_data={10,11,12} and out_col=0.
  - shift asserted on the swap cycle is dropped.
- Illegal swap: swap while FILLING (2 beats loaded) is ignored.
  - active is unchanged and the 3rd beat still completes the fill.
- Clear priority: clear with in_valid, swap and shift all high.
  - Next cycle all outputs 0, in_ready=1, active_valid=0, and later shifts are ignored.
- Async reset: assert rst_n mid-rotation, between edges.
  - out_data=0 and wrap=0 immediately, without waiting for a clock edge.
